rvb_pcpi_unit: RTL and testbench
================================

# rvb_pcpi_unit

PCPI coprocessor executing a subset of the RISC-V bit-manipulation (draft v0.92) R-type instructions on behalf of a picorv32 core (RV32, PCPI and PCPI_RS3 enabled). It snoops every PCPI request and decodes the instruction word. For a supported instruction it holds `pcpi_wait`, computes the result with a fixed per-class latency, and returns it with a one-cycle `pcpi_ready`/`pcpi_wr` pulse.

## Interface
- Parameters: none.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pcpi_valid` in 1: core request.
- `pcpi_insn` in 32: instruction word.
- `pcpi_rs1`, `pcpi_rs2`, `pcpi_rs3` in 32 each: operands.
- `pcpi_wr` out 1: write rd; identical to `pcpi_ready`.
- `pcpi_rd` out 32: result.
- `pcpi_wait` out 1: busy.
- `pcpi_ready` out 1: result valid.
- `debug_rs2` out 32: `pcpi_rs2` captured at acceptance.
- `debug_insn_simple`, `debug_insn_shifter`, `debug_insn_bitcnt`, `debug_insn_clmul`, `debug_insn_crc` out 1 each: combinational class decode of `pcpi_insn` AND `pcpi_valid`.
- `debug_insn_bextdep`, `debug_insn_bmatxor` out 1 each: unimplemented classes, constant 0.

## Operation
Decode is on OP (0110011) unless noted; f7/f3 are funct7/funct3.
- **simple**
  - andn f7=0100000 f3=111: rs1&~rs2. orn 0100000/110: rs1|~rs2. xnor 0100000/100: ~(rs1^rs2).
  - min/max/minu/maxu: f7=0000101, f3=100/101/110/111. min/max signed; minu/maxu unsigned.
  - cmix (insn[26:25]=11, f3=001): (rs1&rs2)|(rs3&~rs2).
  - cmov (insn[26:25]=11, f3=101): rs2!=0 ? rs1 : rs3.
- **shifter** (shamt=rs2[4:0])
  - slo 0010000/001: shift left, fill ones. sro 0010000/101: shift right, fill ones.
  - rol 0110000/001, ror 0110000/101: rotate.
  - sbset 0010100/001, sbclr 0100100/001, sbinv 0110100/001: set/clear/invert bit shamt of rs1.
  - sbext 0100100/101: rs1[shamt] zero-extended.
- **bitcnt** (OP-IMM 0010011, f3=001, insn[31:20] = 0x600/0x601/0x602)
  - clz, ctz: return 32 for input 0.
  - pcnt: population count.
- **clmul** f7=0000101, f3=001/010/011: carry-less product of rs1, rs2. clmul returns product[31:0], clmulr product[62:31], clmulh product[63:32].
- **crc** (OP-IMM, f3=001, insn[31:25]=0110000, insn[24:20]=10000/10001/10010 crc32.b/h/w, 11000/11001/11010 crc32c.b/h/w)
  - nbits = 8<<insn[21:20].
  - Repeat nbits times: x=(x>>1)^(x[0]?P:0), starting from x=rs1.
  - P=0xEDB88320 (crc32), 0x82F63B78 (crc32c).
  - Size 11 (.d) is unsupported.
- Unsupported instruction: `pcpi_wait`=0, `pcpi_ready`=0, no state change.

## Timing
- Acceptance: cycle N is the first cycle with `pcpi_valid`=1 after a cycle with `pcpi_valid`=0, and the instruction is supported. Operands and the instruction are latched at the end of cycle N. A valid that stays high never re-triggers.
- `pcpi_wait` = `pcpi_valid` AND supported, combinational, from cycle N until valid drops.
- `pcpi_ready`=`pcpi_wr`=1 for exactly one cycle, cycle N+L:
  - L=2 for simple, shifter, bitcnt.
  - L=7 for clmul.
  - L=2+bytes for crc, processing 8 bits per cycle: .b=3, .h=4, .w=6.
- `pcpi_rd` is registered. It holds the result during the ready cycle and keeps it until the next result.
- State machine: IDLE → BUSY (countdown L-1) → DONE (one cycle, ready) → IDLE.
- If `pcpi_valid` falls during BUSY, abort to IDLE; no ready is issued.
- Reset (any time): state IDLE; `pcpi_ready`, `pcpi_wr`, `pcpi_rd`, `debug_rs2` = 0. A pending operation is discarded.

## Configuration
- `RVB_CRC_EN` defined: crc class decoded and executed as above.
- `RVB_CRC_EN` undefined: crc logic is omitted; crc encodings are unsupported (no wait, no ready) and `debug_insn_crc` is constant 0.

## Test plan
- andn rs1=0xFF00FF00, rs2=0x0F0F0F0F → rd=0xF000F000, ready only in cycle N+2. min rs1=0xFFFFFFFF, rs2=1 → 0xFFFFFFFF; minu with the same operands → 1.
- rol rs1=0x80000001, rs2=1 → 0x00000003. sbext rs1=0x10, rs2=4 → 1.
- clz 0x00010000 → 15; ctz 0 → 32; pcnt 0xF0F0F0F0 → 16; each ready at N+2.
- clmul 3,3 → 5; clmulh 0x80000000,2 → 1; ready at N+7, `pcpi_wait` high in cycles N..N+7.
- crc32.b 0x80 → 0xEDB88320, ready at N+3. crc32c.b 0x80 → 0x82F63B78. crc32.w 0 → 0, ready at N+6.
- Robustness:
  - Unsupported instruction (e.g. add) → wait=0, ready=0.
  - Valid held high after ready → no second ready.
  - Reset asserted at N+3 of a clmul → no ready, rd=0.

Source files
------------

// File: rtl/rvb_pcpi_unit.sv
// rvb_pcpi_unit: PCPI coprocessor for a subset of RISC-V bit-manipulation ops.
// Snoops PCPI requests, holds pcpi_wait on supported instructions, and
// returns the result with a one-cycle pcpi_ready/pcpi_wr pulse after a fixed
// per-class latency.
// Optional feature macro: RVB_CRC_EN enables the crc32/crc32c class.
module rvb_pcpi_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    input  logic [31:0] pcpi_rs3,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic [31:0] debug_rs2,
    output logic        debug_insn_simple,
    output logic        debug_insn_shifter,
    output logic        debug_insn_bitcnt,
    output logic        debug_insn_clmul,
    output logic        debug_insn_crc,
    output logic        debug_insn_bextdep,
    output logic        debug_insn_bmatxor
);

    typedef enum logic [4:0] {
        OP_NONE, OP_ANDN, OP_ORN, OP_XNOR, OP_MIN, OP_MAX, OP_MINU, OP_MAXU,
        OP_CMIX, OP_CMOV, OP_SLO, OP_SRO, OP_ROL, OP_ROR, OP_SBSET, OP_SBCLR,
        OP_SBINV, OP_SBEXT, OP_CLZ, OP_CTZ, OP_PCNT, OP_CLMUL, OP_CLMULR,
        OP_CLMULH, OP_CRC32, OP_CRC32C
    } op_t;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    op_t         dec_op;
    logic        cls_simple, cls_shifter, cls_bitcnt, cls_clmul;
    logic [2:0]  lat_load;
    state_t      state;
    logic        valid_q;
    op_t         op_q;
    logic [31:0] rs1_q, rs2_q, rs3_q;
    logic [2:0]  count;
    logic [4:0]  shamt;
    logic [63:0] prod;
    logic [31:0] result;
    logic        unused_insn_fields;

`ifdef RVB_CRC_EN
    logic        cls_crc;
    logic [2:0]  dec_bytes;
    logic [31:0] crc_x;
    logic [2:0]  crc_left;
`endif

    assign opcode = pcpi_insn[6:0];
    assign f3     = pcpi_insn[14:12];
    assign f7     = pcpi_insn[31:25];
    assign unused_insn_fields = ^{pcpi_insn[19:15], pcpi_insn[11:7]};

    function automatic logic [5:0] count_lead(input logic [31:0] x);
        logic [5:0] n;
        logic       hit;
        n   = 6'd0;
        hit = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) hit = 1'b1;
            else if (!hit) n = n + 6'd1;
        end
        return n;
    endfunction

    function automatic logic [5:0] count_trail(input logic [31:0] x);
        logic [5:0] n;
        logic       hit;
        n   = 6'd0;
        hit = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) hit = 1'b1;
            else if (!hit) n = n + 6'd1;
        end
        return n;
    endfunction

    function automatic logic [5:0] count_ones(input logic [31:0] x);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) n = n + {5'd0, x[i]};
        return n;
    endfunction

    function automatic logic [63:0] clmul64(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'd0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) p = p ^ ({32'd0, a} << i);
        end
        return p;
    endfunction

`ifdef RVB_CRC_EN
    function automatic logic [31:0] crc_byte(input logic [31:0] x, input logic [31:0] poly);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < 8; i++) y = (y >> 1) ^ (y[0] ? poly : 32'd0);
        return y;
    endfunction
`endif

    // Decode the live instruction word into an operation (OP_NONE if unsupported)
    always_comb begin
        dec_op = OP_NONE;
`ifdef RVB_CRC_EN
        dec_bytes = 3'd1;
`endif
        if (opcode == OPC_OP) begin
            if (pcpi_insn[26:25] == 2'b11) begin
                if (f3 == 3'b001) dec_op = OP_CMIX;
                else if (f3 == 3'b101) dec_op = OP_CMOV;
            end else begin
                case ({f7, f3})
                    {7'b0100000, 3'b111}: dec_op = OP_ANDN;
                    {7'b0100000, 3'b110}: dec_op = OP_ORN;
                    {7'b0100000, 3'b100}: dec_op = OP_XNOR;
                    {7'b0000101, 3'b100}: dec_op = OP_MIN;
                    {7'b0000101, 3'b101}: dec_op = OP_MAX;
                    {7'b0000101, 3'b110}: dec_op = OP_MINU;
                    {7'b0000101, 3'b111}: dec_op = OP_MAXU;
                    {7'b0010000, 3'b001}: dec_op = OP_SLO;
                    {7'b0010000, 3'b101}: dec_op = OP_SRO;
                    {7'b0110000, 3'b001}: dec_op = OP_ROL;
                    {7'b0110000, 3'b101}: dec_op = OP_ROR;
                    {7'b0010100, 3'b001}: dec_op = OP_SBSET;
                    {7'b0100100, 3'b001}: dec_op = OP_SBCLR;
                    {7'b0110100, 3'b001}: dec_op = OP_SBINV;
                    {7'b0100100, 3'b101}: dec_op = OP_SBEXT;
                    {7'b0000101, 3'b001}: dec_op = OP_CLMUL;
                    {7'b0000101, 3'b010}: dec_op = OP_CLMULR;
                    {7'b0000101, 3'b011}: dec_op = OP_CLMULH;
                    default:              dec_op = OP_NONE;
                endcase
            end
        end else if (opcode == OPC_IMM && f3 == 3'b001) begin
            case (pcpi_insn[31:20])
                12'h600: dec_op = OP_CLZ;
                12'h601: dec_op = OP_CTZ;
                12'h602: dec_op = OP_PCNT;
                default: dec_op = OP_NONE;
            endcase
`ifdef RVB_CRC_EN
            if (f7 == 7'b0110000 && pcpi_insn[24] && !pcpi_insn[22] &&
                pcpi_insn[21:20] != 2'b11) begin
                dec_op    = pcpi_insn[23] ? OP_CRC32C : OP_CRC32;
                dec_bytes = 3'd1 << pcpi_insn[21:20];
            end
`endif
        end
    end

    // Group the decoded operation into classes and pick the countdown preload
    always_comb begin
        cls_simple  = dec_op inside {OP_ANDN, OP_ORN, OP_XNOR, OP_MIN, OP_MAX,
                                     OP_MINU, OP_MAXU, OP_CMIX, OP_CMOV};
        cls_shifter = dec_op inside {OP_SLO, OP_SRO, OP_ROL, OP_ROR, OP_SBSET,
                                     OP_SBCLR, OP_SBINV, OP_SBEXT};
        cls_bitcnt  = dec_op inside {OP_CLZ, OP_CTZ, OP_PCNT};
        cls_clmul   = dec_op inside {OP_CLMUL, OP_CLMULR, OP_CLMULH};
        lat_load    = cls_clmul ? 3'd5 : 3'd0;
`ifdef RVB_CRC_EN
        cls_crc = dec_op inside {OP_CRC32, OP_CRC32C};
        if (cls_crc) lat_load = dec_bytes;
`endif
    end

    assign pcpi_wait          = pcpi_valid && (dec_op != OP_NONE);
    assign pcpi_wr            = pcpi_ready;
    assign debug_rs2          = rs2_q;
    assign debug_insn_simple  = pcpi_valid && cls_simple;
    assign debug_insn_shifter = pcpi_valid && cls_shifter;
    assign debug_insn_bitcnt  = pcpi_valid && cls_bitcnt;
    assign debug_insn_clmul   = pcpi_valid && cls_clmul;
`ifdef RVB_CRC_EN
    assign debug_insn_crc     = pcpi_valid && cls_crc;
`else
    assign debug_insn_crc     = 1'b0;
`endif
    assign debug_insn_bextdep = 1'b0;
    assign debug_insn_bmatxor = 1'b0;

    assign shamt = rs2_q[4:0];
    assign prod  = clmul64(rs1_q, rs2_q);

    // Compute the result of the latched operation from the latched operands
    always_comb begin
        result = 32'd0;
        case (op_q)
            OP_ANDN:   result = rs1_q & ~rs2_q;
            OP_ORN:    result = rs1_q | ~rs2_q;
            OP_XNOR:   result = ~(rs1_q ^ rs2_q);
            OP_MIN:    result = ($signed(rs1_q) < $signed(rs2_q)) ? rs1_q : rs2_q;
            OP_MAX:    result = ($signed(rs1_q) > $signed(rs2_q)) ? rs1_q : rs2_q;
            OP_MINU:   result = (rs1_q < rs2_q) ? rs1_q : rs2_q;
            OP_MAXU:   result = (rs1_q > rs2_q) ? rs1_q : rs2_q;
            OP_CMIX:   result = (rs1_q & rs2_q) | (rs3_q & ~rs2_q);
            OP_CMOV:   result = (rs2_q != 32'd0) ? rs1_q : rs3_q;
            OP_SLO:    result = ~(~rs1_q << shamt);
            OP_SRO:    result = ~(~rs1_q >> shamt);
            OP_ROL:    result = (rs1_q << shamt) | (rs1_q >> (6'd32 - {1'b0, shamt}));
            OP_ROR:    result = (rs1_q >> shamt) | (rs1_q << (6'd32 - {1'b0, shamt}));
            OP_SBSET:  result = rs1_q | (32'd1 << shamt);
            OP_SBCLR:  result = rs1_q & ~(32'd1 << shamt);
            OP_SBINV:  result = rs1_q ^ (32'd1 << shamt);
            OP_SBEXT:  result = {31'd0, rs1_q[shamt]};
            OP_CLZ:    result = {26'd0, count_lead(rs1_q)};
            OP_CTZ:    result = {26'd0, count_trail(rs1_q)};
            OP_PCNT:   result = {26'd0, count_ones(rs1_q)};
            OP_CLMUL:  result = prod[31:0];
            OP_CLMULR: result = prod[62:31];
            OP_CLMULH: result = prod[63:32];
`ifdef RVB_CRC_EN
            OP_CRC32,
            OP_CRC32C: result = crc_x;
`endif
            default:   result = 32'd0;
        endcase
    end

    // Request tracking FSM: accept on a fresh valid, count down, pulse ready once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            valid_q    <= 1'b0;
            op_q       <= OP_NONE;
            rs1_q      <= 32'd0;
            rs2_q      <= 32'd0;
            rs3_q      <= 32'd0;
            count      <= 3'd0;
            pcpi_ready <= 1'b0;
            pcpi_rd    <= 32'd0;
`ifdef RVB_CRC_EN
            crc_x      <= 32'd0;
            crc_left   <= 3'd0;
`endif
        end else begin
            valid_q    <= pcpi_valid;
            pcpi_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pcpi_valid && !valid_q && dec_op != OP_NONE) begin
                        op_q  <= dec_op;
                        rs1_q <= pcpi_rs1;
                        rs2_q <= pcpi_rs2;
                        rs3_q <= pcpi_rs3;
                        count <= lat_load;
                        state <= ST_BUSY;
`ifdef RVB_CRC_EN
                        crc_x    <= pcpi_rs1;
                        crc_left <= cls_crc ? dec_bytes : 3'd0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (!pcpi_valid) begin
                        state <= ST_IDLE;
                    end else begin
                        if (count == 3'd0) begin
                            pcpi_rd    <= result;
                            pcpi_ready <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            count <= count - 3'd1;
                        end
`ifdef RVB_CRC_EN
                        if (crc_left != 3'd0) begin
                            crc_x    <= crc_byte(crc_x, (op_q == OP_CRC32C) ?
                                                 32'h82F63B78 : 32'hEDB88320);
                            crc_left <= crc_left - 3'd1;
                        end
`endif
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvb_pcpi_unit.sv
// tb_rvb_pcpi_unit: self-checking bench for rvb_pcpi_unit with directed
// cases and randomized transactions against a behavioural reference model.
// Honours RVB_CRC_EN the same way as the design.
module tb_rvb_pcpi_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pcpi_valid = 1'b0;
    logic [31:0] pcpi_insn = 32'd0;
    logic [31:0] pcpi_rs1 = 32'd0, pcpi_rs2 = 32'd0, pcpi_rs3 = 32'd0;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd, debug_rs2;
    logic        debug_insn_simple, debug_insn_shifter, debug_insn_bitcnt;
    logic        debug_insn_clmul, debug_insn_crc, debug_insn_bextdep, debug_insn_bmatxor;

    int total = 0;
    int bad = 0;

`ifdef RVB_CRC_EN
    localparam int NK = 29;
`else
    localparam int NK = 23;
`endif

    // Operation kind numbers used by the bench only
    localparam int K_ANDN = 0, K_MIN = 3, K_MINU = 5, K_ROL = 11, K_SBEXT = 16;
    localparam int K_CLZ = 17, K_CTZ = 18, K_PCNT = 19, K_CLMUL = 20, K_CLMULH = 22;
    localparam int K_CRC32B = 23, K_CRC32W = 25, K_CRC32CB = 26;

    rvb_pcpi_unit dut (
        .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_rs3(pcpi_rs3),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait),
        .pcpi_ready(pcpi_ready), .debug_rs2(debug_rs2),
        .debug_insn_simple(debug_insn_simple), .debug_insn_shifter(debug_insn_shifter),
        .debug_insn_bitcnt(debug_insn_bitcnt), .debug_insn_clmul(debug_insn_clmul),
        .debug_insn_crc(debug_insn_crc), .debug_insn_bextdep(debug_insn_bextdep),
        .debug_insn_bmatxor(debug_insn_bmatxor)
    );

    always #5 clk = ~clk;

    // Build an instruction word for a kind, with random don't-care register fields
    function automatic logic [31:0] insn_of(input int k);
        logic [4:0] r1, rd, r2, r3;
        logic [6:0] f7;
        logic [2:0] f3;
        r1 = 5'($urandom); rd = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom);
        case (k)
            0:  begin f7 = 7'b0100000; f3 = 3'b111; end
            1:  begin f7 = 7'b0100000; f3 = 3'b110; end
            2:  begin f7 = 7'b0100000; f3 = 3'b100; end
            3:  begin f7 = 7'b0000101; f3 = 3'b100; end
            4:  begin f7 = 7'b0000101; f3 = 3'b101; end
            5:  begin f7 = 7'b0000101; f3 = 3'b110; end
            6:  begin f7 = 7'b0000101; f3 = 3'b111; end
            7:  begin f7 = {r3, 2'b11}; f3 = 3'b001; end
            8:  begin f7 = {r3, 2'b11}; f3 = 3'b101; end
            9:  begin f7 = 7'b0010000; f3 = 3'b001; end
            10: begin f7 = 7'b0010000; f3 = 3'b101; end
            11: begin f7 = 7'b0110000; f3 = 3'b001; end
            12: begin f7 = 7'b0110000; f3 = 3'b101; end
            13: begin f7 = 7'b0010100; f3 = 3'b001; end
            14: begin f7 = 7'b0100100; f3 = 3'b001; end
            15: begin f7 = 7'b0110100; f3 = 3'b001; end
            16: begin f7 = 7'b0100100; f3 = 3'b101; end
            20: begin f7 = 7'b0000101; f3 = 3'b001; end
            21: begin f7 = 7'b0000101; f3 = 3'b010; end
            22: begin f7 = 7'b0000101; f3 = 3'b011; end
            default: begin f7 = 7'b0110000; f3 = 3'b001; end
        endcase
        if (k >= 17 && k <= 19) return {7'b0110000, 5'(k - 17), r1, 3'b001, rd, 7'b0010011};
        if (k >= 23) begin
            r2 = (k >= 26) ? 5'b11000 : 5'b10000;
            r2[1:0] = 2'((k - 23) % 3);
            return {7'b0110000, r2, r1, 3'b001, rd, 7'b0010011};
        end
        return {f7, r2, r1, f3, rd, 7'b0110011};
    endfunction

    // Reference result computed straight from the instruction definitions
    function automatic logic [31:0] model(input int k, input logic [31:0] a, b, c);
        logic [31:0] x;
        logic [63:0] p;
        int sh, n;
        sh = int'(b[4:0]);
        x = a;
        p = 64'd0;
        n = 0;
        case (k)
            0: return a & ~b;
            1: return a | ~b;
            2: return ~(a ^ b);
            3: return (int'(a) < int'(b)) ? a : b;
            4: return (int'(a) > int'(b)) ? a : b;
            5: return (longint'(a) < longint'(b)) ? a : b;
            6: return (longint'(a) > longint'(b)) ? a : b;
            7: return (a & b) | (c & ~b);
            8: return (b != 0) ? a : c;
            9:  begin for (int i = 0; i < sh; i++) x = {x[30:0], 1'b1}; return x; end
            10: begin for (int i = 0; i < sh; i++) x = {1'b1, x[31:1]}; return x; end
            11: begin for (int i = 0; i < sh; i++) x = {x[30:0], x[31]}; return x; end
            12: begin for (int i = 0; i < sh; i++) x = {x[0], x[31:1]}; return x; end
            13: begin x[sh] = 1'b1; return x; end
            14: begin x[sh] = 1'b0; return x; end
            15: begin x[sh] = ~x[sh]; return x; end
            16: return {31'd0, a[sh]};
            17: begin while (n < 32 && a[31 - n] == 1'b0) n++; return 32'(n); end
            18: begin while (n < 32 && a[n] == 1'b0) n++; return 32'(n); end
            19: return 32'($countones(a));
            20, 21, 22: begin
                for (int i = 0; i < 32; i++)
                    for (int j = 0; j < 32; j++)
                        if (a[i] && b[j]) p[i + j] = ~p[i + j];
                if (k == 20) return p[31:0];
                if (k == 21) return p[62:31];
                return p[63:32];
            end
            default: begin
                for (int i = 0; i < (8 << ((k - 23) % 3)); i++)
                    x = (x >> 1) ^ (x[0] ? ((k >= 26) ? 32'h82F63B78 : 32'hEDB88320) : 32'd0);
                return x;
            end
        endcase
    endfunction

    function automatic int model_lat(input int k);
        if (k <= 19) return 2;
        if (k <= 22) return 7;
        return 2 + (1 << ((k - 23) % 3));
    endfunction

    // Expected {simple, shifter, bitcnt, clmul, crc, bextdep, bmatxor} flags
    function automatic logic [6:0] model_dbg(input int k);
        if (k <= 8) return 7'b1000000;
        if (k <= 16) return 7'b0100000;
        if (k <= 19) return 7'b0010000;
        if (k <= 22) return 7'b0001000;
        return 7'b0000100;
    endfunction

    // Drive one request and observe it: first wait, debug flags, latency, result
    task automatic do_txn(input logic [31:0] insn, a, b, c, output int lat,
                          output logic [31:0] rd, output bit wait_ok, output logic w0,
                          output logic [6:0] dbg, output logic wr);
        lat = -1; rd = 32'd0; wait_ok = 1'b1; w0 = 1'b0; dbg = 7'd0; wr = 1'b0;
        @(negedge clk);
        pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b; pcpi_rs3 = c;
        pcpi_valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (cyc == 0) begin
                w0 = pcpi_wait;
                dbg = {debug_insn_simple, debug_insn_shifter, debug_insn_bitcnt,
                       debug_insn_clmul, debug_insn_crc, debug_insn_bextdep, debug_insn_bmatxor};
            end
            if (pcpi_wait !== 1'b1) wait_ok = 1'b0;
            if (pcpi_ready === 1'b1) begin
                lat = cyc; rd = pcpi_rd; wr = pcpi_wr;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        pcpi_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        total++; if (pcpi_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", pcpi_ready); end
        total++; if (pcpi_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b want=0", pcpi_wr); end
        total++; if (pcpi_rd !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h want=0", pcpi_rd); end
        total++; if (debug_rs2 !== 32'd0) begin bad++; $display("FAIL reset_rs2 got=%h want=0", debug_rs2); end
        total++; if (pcpi_wait !== 1'b0) begin bad++; $display("FAIL reset_wait got=%b want=0", pcpi_wait); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simple();
        int lat; logic [31:0] rd; bit wok; logic w0, wr; logic [6:0] dbg;
        do_txn(insn_of(K_ANDN), 32'hFF00FF00, 32'h0F0F0F0F, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'hF000F000) begin bad++; $display("FAIL andn_rd got=%h want=f000f000", rd); end
        total++; if (lat != 2) begin bad++; $display("FAIL andn_lat got=%0d want=2", lat); end
        do_txn(insn_of(K_MIN), 32'hFFFFFFFF, 32'd1, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'hFFFFFFFF) begin bad++; $display("FAIL min_rd got=%h want=ffffffff", rd); end
        do_txn(insn_of(K_MINU), 32'hFFFFFFFF, 32'd1, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'd1) begin bad++; $display("FAIL minu_rd got=%h want=1", rd); end
    endtask

    task automatic test_shifter();
        int lat; logic [31:0] rd; bit wok; logic w0, wr; logic [6:0] dbg;
        do_txn(insn_of(K_ROL), 32'h80000001, 32'd1, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'h00000003) begin bad++; $display("FAIL rol_rd got=%h want=3", rd); end
        do_txn(insn_of(K_SBEXT), 32'h10, 32'd4, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'd1) begin bad++; $display("FAIL sbext_rd got=%h want=1", rd); end
    endtask

    task automatic test_bitcnt();
        int lat; logic [31:0] rd; bit wok; logic w0, wr; logic [6:0] dbg;
        do_txn(insn_of(K_CLZ), 32'h00010000, 32'd0, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'd15 || lat != 2) begin bad++; $display("FAIL clz got=%0d lat=%0d want=15 lat=2", rd, lat); end
        do_txn(insn_of(K_CTZ), 32'd0, 32'd0, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'd32 || lat != 2) begin bad++; $display("FAIL ctz got=%0d lat=%0d want=32 lat=2", rd, lat); end
        do_txn(insn_of(K_PCNT), 32'hF0F0F0F0, 32'd0, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'd16 || lat != 2) begin bad++; $display("FAIL pcnt got=%0d lat=%0d want=16 lat=2", rd, lat); end
    endtask

    task automatic test_clmul();
        int lat; logic [31:0] rd; bit wok; logic w0, wr; logic [6:0] dbg;
        do_txn(insn_of(K_CLMUL), 32'd3, 32'd3, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'd5) begin bad++; $display("FAIL clmul_rd got=%h want=5", rd); end
        total++; if (lat != 7) begin bad++; $display("FAIL clmul_lat got=%0d want=7", lat); end
        total++; if (wok !== 1'b1) begin bad++; $display("FAIL clmul_wait got=%b want=1", wok); end
        do_txn(insn_of(K_CLMULH), 32'h80000000, 32'd2, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'd1) begin bad++; $display("FAIL clmulh_rd got=%h want=1", rd); end
    endtask

    task automatic test_crc();
        int lat; logic [31:0] rd; bit wok; logic w0, wr; logic [6:0] dbg;
`ifdef RVB_CRC_EN
        do_txn(insn_of(K_CRC32B), 32'h80, 32'd0, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'hEDB88320 || lat != 3) begin bad++; $display("FAIL crc32b got=%h lat=%0d want=edb88320 lat=3", rd, lat); end
        do_txn(insn_of(K_CRC32CB), 32'h80, 32'd0, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'h82F63B78) begin bad++; $display("FAIL crc32cb got=%h want=82f63b78", rd); end
        do_txn(insn_of(K_CRC32W), 32'd0, 32'd0, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (rd !== 32'd0 || lat != 6) begin bad++; $display("FAIL crc32w got=%h lat=%0d want=0 lat=6", rd, lat); end
`else
        do_txn(insn_of(K_CRC32B), 32'h80, 32'd0, 32'd0, lat, rd, wok, w0, dbg, wr);
        total++; if (lat != -1 || w0 !== 1'b0) begin bad++; $display("FAIL crc_off lat=%0d wait=%b want=-1 wait=0", lat, w0); end
        total++; if (dbg !== 7'd0) begin bad++; $display("FAIL crc_off_dbg got=%b want=0", dbg); end
`endif
    endtask

    task automatic test_unsupported();
        int lat; logic [31:0] rd; bit wok; logic w0, wr; logic [6:0] dbg;
        do_txn({7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011}, 32'd5, 32'd6, 32'd0,
               lat, rd, wok, w0, dbg, wr);
        total++; if (lat != -1 || w0 !== 1'b0) begin bad++; $display("FAIL add_unsup lat=%0d wait=%b want=-1 wait=0", lat, w0); end
        total++; if (dbg !== 7'd0) begin bad++; $display("FAIL add_dbg got=%b want=0", dbg); end
        do_txn({7'b0110000, 5'b10011, 5'd2, 3'b001, 5'd1, 7'b0010011}, 32'd5, 32'd6, 32'd0,
               lat, rd, wok, w0, dbg, wr);
        total++; if (lat != -1 || w0 !== 1'b0) begin bad++; $display("FAIL crcd_unsup lat=%0d wait=%b want=-1 wait=0", lat, w0); end
    endtask

    task automatic test_hold_valid();
        int readies = 0;
        @(negedge clk);
        pcpi_insn = insn_of(K_ANDN); pcpi_rs1 = 32'h12345678; pcpi_rs2 = 32'h0000FFFF;
        pcpi_valid = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            if (pcpi_ready === 1'b1) readies++;
            @(negedge clk);
        end
        pcpi_valid = 1'b0;
        total++; if (readies != 1) begin bad++; $display("FAIL hold_readies got=%0d want=1", readies); end
        total++; if (pcpi_rd !== 32'h12340000) begin bad++; $display("FAIL hold_rd got=%h want=12340000", pcpi_rd); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int readies = 0;
        @(negedge clk);
        pcpi_insn = insn_of(K_CLMUL); pcpi_rs1 = 32'd7; pcpi_rs2 = 32'd7;
        pcpi_valid = 1'b1;
        repeat (3) @(negedge clk);
        pcpi_valid = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (pcpi_ready === 1'b1) readies++;
            @(negedge clk);
        end
        total++; if (readies != 0) begin bad++; $display("FAIL abort_readies got=%0d want=0", readies); end
    endtask

    task automatic test_reset_mid();
        int readies = 0;
        @(negedge clk);
        pcpi_insn = insn_of(K_CLMUL); pcpi_rs1 = 32'd3; pcpi_rs2 = 32'd3;
        pcpi_valid = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (pcpi_rd !== 32'd0) begin bad++; $display("FAIL rstmid_rd got=%h want=0", pcpi_rd); end
        @(negedge clk);
        pcpi_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (pcpi_ready === 1'b1) readies++;
            @(negedge clk);
        end
        total++; if (readies != 0) begin bad++; $display("FAIL rstmid_readies got=%0d want=0", readies); end
        total++; if (pcpi_rd !== 32'd0) begin bad++; $display("FAIL rstmid_rd_after got=%h want=0", pcpi_rd); end
    endtask

    task automatic test_random();
        int lat, k; logic [31:0] rd, a, b, c, exp; bit wok; logic w0, wr; logic [6:0] dbg;
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, NK - 1);
            case ($urandom_range(0, 3))
                0: a = 32'd0;
                1: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            c = $urandom;
            exp = model(k, a, b, c);
            do_txn(insn_of(k), a, b, c, lat, rd, wok, w0, dbg, wr);
            total++; if (rd !== exp) begin bad++; $display("FAIL rand_rd k=%0d a=%h b=%h c=%h got=%h want=%h", k, a, b, c, rd, exp); end
            total++; if (lat != model_lat(k)) begin bad++; $display("FAIL rand_lat k=%0d got=%0d want=%0d", k, lat, model_lat(k)); end
            total++; if (wok !== 1'b1) begin bad++; $display("FAIL rand_wait k=%0d got=%b want=1", k, wok); end
            total++; if (dbg !== model_dbg(k)) begin bad++; $display("FAIL rand_dbg k=%0d got=%b want=%b", k, dbg, model_dbg(k)); end
            total++; if (wr !== 1'b1) begin bad++; $display("FAIL rand_wr k=%0d got=%b want=1", k, wr); end
            total++; if (debug_rs2 !== b) begin bad++; $display("FAIL rand_rs2 k=%0d got=%h want=%h", k, debug_rs2, b); end
        end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_shifter();
        test_bitcnt();
        test_clmul();
        test_crc();
        test_unsupported();
        test_hold_valid();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
